// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from N_REQ requesters into a single UART
// transmitter, with a per-frame watchdog on the transmitter's done pulse.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 200_000
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_REQ-1:0]           i_req_valid,
    input  logic [N_REQ*DATA_W-1:0]    i_req_data,
    output logic [N_REQ-1:0]           o_req_ready,
    output logic [DATA_W-1:0]          o_tx_data,
    output logic                       o_tx_enable,
    input  logic                       i_tx_done,
    output logic [$clog2(N_REQ)-1:0]   o_grant_id,
    output logic                       o_busy,
    output logic                       o_timeout
);

    localparam int unsigned GW       = $clog2(N_REQ);
    localparam int unsigned WD_W     = 32;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0]   LAST_RST = GW'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t            state;
    logic [GW-1:0]     last_grant;
    logic [WD_W-1:0]   wdog;

    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic [GW-1:0]     cand;
    logic [N_REQ-1:0]  win_onehot;
    logic [DATA_W-1:0] win_data;

    // Search starts just after the previous winner and checks it last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = GW'((32'(last_grant) + i) % N_REQ);
            if (!win_found && i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Decode the winner into a one-hot strobe and select its byte.
    always_comb begin
        win_onehot = '0;
        win_data   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (win_found && (win_idx == GW'(k))) begin
                win_onehot[k] = 1'b1;
                win_data      = i_req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign o_req_ready = ((state == S_IDLE) && !i_rst) ? win_onehot : '0;
    assign o_busy      = (state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_tx_enable <= 1'b0;
            o_tx_data   <= '0;
            o_grant_id  <= '0;
            o_timeout   <= 1'b0;
            wdog        <= '0;
            last_grant  <= LAST_RST;
        end else begin
            o_tx_enable <= 1'b0;
            o_timeout   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        o_tx_data   <= win_data;
                        o_grant_id  <= win_idx;
                        last_grant  <= win_idx;
                        o_tx_enable <= 1'b1;
                        state       <= S_START;
                    end
                end
                S_START: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Done takes priority over a watchdog expiring on the same edge.
                    if (i_tx_done) begin
                        wdog  <= '0;
                        state <= S_IDLE;
                    end else if (wdog == WD_LIMIT) begin
                        wdog      <= '0;
                        o_timeout <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
